ps2_line_builder: RTL and testbench

PS2_LINE_BUILDER -- requirements
Module: ps2_line_builder

---
 rtl/ps2_line_builder.sv | 147 ++++++++++++++
 tb/tb_ps2_line_builder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_line_builder.sv
// Line editor for decoded PS/2 keystrokes: builds a 32-character line, supports
// backspace, and on ENTER publishes the line with a one-cycle ready pulse.
module ps2_line_builder #(
    parameter logic [7:0] BKSP_CODE  = 8'h08,
    parameter logic [7:0] ENTER_CODE = 8'h0D
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [7:0]   ps2_key_data,
    input  logic         ps2_key_pressed,
    output logic [255:0] ps2_line_content,
    output logic [255:0] committed_line,
    output logic         ps2_line_ready,
    output logic [5:0]   line_length,
    output logic         key_dropped
);

    typedef enum logic [1:0] {
        ST_EDIT   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   content_q, content_d;
    logic [255:0]   committed_q, committed_d;
    logic [5:0]     len_q, len_d;
    logic           ready_q, ready_d;
    logic           drop_q, drop_d;
    logic [5:0]     len_dec_s;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

    // Character idx lives at bits [255-8*idx -: 8]; shift distance is 8*(31-idx).
    function automatic logic [255:0] place_byte(input logic [255:0] line,
                                                input logic [4:0]   idx,
                                                input logic [7:0]   value);
        logic [7:0] shift;
        shift = {~idx, 3'b000};
        return (line & ~({248'h0, 8'hFF} << shift)) | ({248'h0, value} << shift);
    endfunction

    assign len_dec_s = len_q - 6'd1;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EDIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EDIT: begin
                if (ps2_key_pressed && (ps2_key_data == ENTER_CODE) && (len_q != 6'd0)) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_EDIT;
                end
            end
            ST_COMMIT: state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_EDIT;
            default:   state_d = ST_EDIT;
        endcase
    end

    // Datapath next values; outputs are registered so each strobe shows after its edge
    always_comb begin
        content_d   = content_q;
        committed_d = committed_q;
        len_d       = len_q;
        ready_d     = 1'b0;
        drop_d      = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (!ps2_key_pressed) begin
                    drop_d = 1'b0;
                end else if (ps2_key_data == BKSP_CODE) begin
                    if (len_q != 6'd0) begin
                        content_d = place_byte(content_q, len_dec_s[4:0], 8'h00);
                        len_d     = len_dec_s;
                    end else begin
                        len_d = len_q;
                    end
                end else if (ps2_key_data == ENTER_CODE) begin
                    if (len_q != 6'd0) begin
                        committed_d = content_q;
                        ready_d     = 1'b1;
                    end else begin
                        ready_d = 1'b0;
                    end
                end else if (is_printable(ps2_key_data)) begin
                    if (len_q < 6'd32) begin
                        content_d = place_byte(content_q, len_q[4:0], ps2_key_data);
                        len_d     = len_q + 6'd1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    drop_d = 1'b0;
                end
            end
            ST_COMMIT: begin
                drop_d = ps2_key_pressed;
            end
            ST_CLEAR: begin
                drop_d    = ps2_key_pressed;
                content_d = 256'h0;
                len_d     = 6'd0;
            end
            default: begin
                content_d = 256'h0;
                len_d     = 6'd0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            content_q   <= 256'h0;
            committed_q <= 256'h0;
            len_q       <= 6'd0;
            ready_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            content_q   <= content_d;
            committed_q <= committed_d;
            len_q       <= len_d;
            ready_q     <= ready_d;
            drop_q      <= drop_d;
        end
    end

    assign ps2_line_content = content_q;
    assign committed_line   = committed_q;
    assign ps2_line_ready   = ready_q;
    assign line_length      = len_q;
    assign key_dropped      = drop_q;

endmodule

// File: tb/tb_ps2_line_builder.sv
// Directed self-checking bench for ps2_line_builder.
module tb_ps2_line_builder;

    logic         clock;
    logic         resetn;
    logic [7:0]   ps2_key_data;
    logic         ps2_key_pressed;
    logic [255:0] ps2_line_content;
    logic [255:0] committed_line;
    logic         ps2_line_ready;
    logic [5:0]   line_length;
    logic         key_dropped;

    int checks_cnt;
    int fail_cnt;

    logic [255:0] exp_line;
    logic [255:0] exp_commit;

    ps2_line_builder dut (
        .clock            (clock),
        .resetn           (resetn),
        .ps2_key_data     (ps2_key_data),
        .ps2_key_pressed  (ps2_key_pressed),
        .ps2_line_content (ps2_line_content),
        .committed_line   (committed_line),
        .ps2_line_ready   (ps2_line_ready),
        .line_length      (line_length),
        .key_dropped      (key_dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe one key for a single cycle; returns at the following negedge.
    task automatic press(input logic [7:0] k);
        ps2_key_data    = k;
        ps2_key_pressed = 1'b1;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic idle();
        ps2_key_pressed = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        checks_cnt      = 0;
        fail_cnt        = 0;
        resetn          = 1'b0;
        ps2_key_data    = 8'h00;
        ps2_key_pressed = 1'b0;
        @(negedge clock);
        @(negedge clock);

        check_val("rst_content", ps2_line_content, 256'h0);
        check_val("rst_commit",  committed_line,   256'h0);
        check_val("rst_len",     {250'h0, line_length}, 256'd0);
        check_val("rst_ready",   {255'h0, ps2_line_ready}, 256'd0);
        check_val("rst_drop",    {255'h0, key_dropped}, 256'd0);

        // First strobe accepted on the first edge after release
        resetn = 1'b1;
        press(8'h41);
        check_val("A_len", {250'h0, line_length}, 256'd1);
        check_val("A_char", {248'h0, ps2_line_content[255:248]}, 256'h41);
        press(8'h42);
        check_val("AB_chars", {240'h0, ps2_line_content[255:240]}, 256'h4142);
        check_val("AB_len", {250'h0, line_length}, 256'd2);
        press(8'h0D);
        exp_commit = {16'h4142, 240'h0};
        check_val("enter_commit", committed_line, exp_commit);
        check_val("enter_ready", {255'h0, ps2_line_ready}, 256'd1);
        idle();
        check_val("ready_pulse_end", {255'h0, ps2_line_ready}, 256'd0);
        idle();
        check_val("cleared_content", ps2_line_content, 256'h0);
        check_val("cleared_len", {250'h0, line_length}, 256'd0);
        check_val("commit_held", committed_line, exp_commit);

        // Backspace, including on empty buffer
        press(8'h58);
        check_val("X_len", {250'h0, line_length}, 256'd1);
        check_val("X_char", {248'h0, ps2_line_content[255:248]}, 256'h58);
        press(8'h08);
        check_val("bs1_len", {250'h0, line_length}, 256'd0);
        check_val("bs1_char", {248'h0, ps2_line_content[255:248]}, 256'h00);
        press(8'h08);
        check_val("bs2_len", {250'h0, line_length}, 256'd0);
        check_val("bs2_drop", {255'h0, key_dropped}, 256'd0);

        // Non-printable ignored
        press(8'h1B);
        check_val("esc_content", ps2_line_content, 256'h0);
        check_val("esc_len", {250'h0, line_length}, 256'd0);
        check_val("esc_drop", {255'h0, key_dropped}, 256'd0);

        // ENTER on empty buffer
        press(8'h0D);
        check_val("empty_enter_ready", {255'h0, ps2_line_ready}, 256'd0);
        idle();
        check_val("empty_enter_commit", committed_line, exp_commit);

        // Fill buffer to capacity then overflow
        exp_line = 256'h0;
        for (int i = 0; i < 32; i++) begin
            press(8'h21 + 8'(i));
            exp_line[255 - 8*i -: 8] = 8'h21 + 8'(i);
            check_val("fill_drop", {255'h0, key_dropped}, 256'd0);
        end
        check_val("full_len", {250'h0, line_length}, 256'd32);
        check_val("full_last", {248'h0, ps2_line_content[7:0]}, 256'h40);
        press(8'h7E);
        check_val("overflow_drop", {255'h0, key_dropped}, 256'd1);
        check_val("overflow_len", {250'h0, line_length}, 256'd32);
        check_val("overflow_content", ps2_line_content, exp_line);
        idle();
        check_val("overflow_drop_end", {255'h0, key_dropped}, 256'd0);
        press(8'h08);
        exp_line[7:0] = 8'h00;
        check_val("full_bs_len", {250'h0, line_length}, 256'd31);
        check_val("full_bs_content", ps2_line_content, exp_line);

        // Key strobed during COMMIT is dropped and not stored
        press(8'h0D);
        check_val("long_commit", committed_line, exp_line);
        check_val("long_ready", {255'h0, ps2_line_ready}, 256'd1);
        press(8'h5A);
        check_val("busy_drop", {255'h0, key_dropped}, 256'd1);
        idle();
        check_val("busy_not_stored", ps2_line_content, 256'h0);
        check_val("busy_len", {250'h0, line_length}, 256'd0);
        check_val("busy_drop_end", {255'h0, key_dropped}, 256'd0);

        // Held strobe counts once per cycle
        ps2_key_data    = 8'h43;
        ps2_key_pressed = 1'b1;
        repeat (3) @(negedge clock);
        ps2_key_pressed = 1'b0;
        check_val("hold_len", {250'h0, line_length}, 256'd3);
        check_val("hold_chars", {232'h0, ps2_line_content[255:232]}, 256'h434343);

        // Reset during COMMIT aborts it
        press(8'h0D);
        check_val("pre_rst_ready", {255'h0, ps2_line_ready}, 256'd1);
        resetn = 1'b0;
        #1;
        check_val("midrst_ready", {255'h0, ps2_line_ready}, 256'd0);
        check_val("midrst_commit", committed_line, 256'h0);
        check_val("midrst_content", ps2_line_content, 256'h0);
        check_val("midrst_len", {250'h0, line_length}, 256'd0);
        @(negedge clock);
        resetn = 1'b1;
        idle();
        check_val("post_rst_ready1", {255'h0, ps2_line_ready}, 256'd0);
        idle();
        check_val("post_rst_ready2", {255'h0, ps2_line_ready}, 256'd0);
        press(8'h51);
        check_val("post_rst_key", {248'h0, ps2_line_content[255:248]}, 256'h51);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
